sop_sweep_checker: RTL and testbench

- Sequential, parametrised successor to the hand-minimised sum-of-minterms circuits.
- Holds one programmable minterm mask per output function and sweeps all 2^N_IN input combinations into an external minimised gate-level circuit (the DUT).
- Compares each DUT output against its mask and reports mismatch count, first failing minterm and a pass flag.
- Sits beside the lab's combinational function blocks as an on-chip exhaustive equivalence checker.

---
 rtl/sop_sweep_checker.sv | 133 +++++++++++++
 tb/tb_sop_sweep_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sop_sweep_checker.sv
// Exhaustive sum-of-minterms equivalence checker: sweeps every input vector into an
// external circuit and compares each output bit against a programmable minterm mask.
// Optional macro SWEEP_SETTLE_EN adds a settle cycle per vector for registered DUTs.
module sop_sweep_checker #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mask_wr,
    input  logic [SEL_W-1:0]     mask_sel,
    input  logic [2**N_IN-1:0]   mask_data,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic [N_OUT-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic                 first_fail_valid,
    output logic [N_IN-1:0]      first_fail_idx
);

    localparam int ERR_W = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        FINISH
    } state_t;

`ifdef SWEEP_SETTLE_EN
    localparam state_t VEC_STATE = SETTLE;
`else
    localparam state_t VEC_STATE = CHECK;
`endif

    state_t                 state, state_next;
    logic [N_IN-1:0]        idx;
    logic [2**N_IN-1:0]     masks [N_OUT];
    logic [N_OUT-1:0]       expect_bits;
    logic                   mismatch;
    logic                   load;
    logic                   check;
    logic                   last;

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        check      = 1'b0;
        last       = (idx == LAST_IDX);
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = VEC_STATE;
                end
            end
            SETTLE: state_next = CHECK;
            CHECK: begin
                check      = 1'b1;
                state_next = last ? FINISH : VEC_STATE;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            expect_bits[j] = masks[j][idx];
        end
        mismatch = |(dut_out ^ expect_bits);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            pass             <= 1'b0;
            // NOTE: the mask array is small and must read back as zero after reset,
            // so it is cleared here rather than left as uninitialised storage.
            for (int j = 0; j < N_OUT; j++) begin
                masks[j] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;

            // A write in the same cycle as start lands before the first vector is checked.
            if (state == IDLE && mask_wr && 32'(mask_sel) < N_OUT) begin
                masks[mask_sel] <= mask_data;
            end

            if (load) begin
                idx              <= '0;
                err_count        <= '0;
                first_fail_valid <= 1'b0;
                first_fail_idx   <= '0;
                pass             <= 1'b0;
            end

            if (check) begin
                if (mismatch) begin
                    err_count <= err_count + ERR_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                end
                // pass is resolved on the last vector so it is already valid with done.
                if (last) begin
                    pass <= (err_count == '0) && !mismatch;
                end else begin
                    idx <= idx + N_IN'(1);
                end
            end
        end
    end

    assign dut_in = idx;
    assign busy   = (state == SETTLE) || (state == CHECK);
    assign done   = (state == FINISH);

endmodule

// File: tb/tb_sop_sweep_checker.sv
// Randomised self-checking bench for sop_sweep_checker; the DUT under test is a
// truth-table model, registered when SWEEP_SETTLE_EN is defined.
module tb_sop_sweep_checker;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int NV    = 2 ** N_IN;
`ifdef SWEEP_SETTLE_EN
    localparam int SWEEP_CYC = 2 * NV + 1;
`else
    localparam int SWEEP_CYC = NV + 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            mask_wr;
    logic [0:0]      mask_sel;
    logic [NV-1:0]   mask_data;
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic [N_OUT-1:0] dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            first_fail_valid;
    logic [N_IN-1:0] first_fail_idx;

    logic [NV-1:0]   dut_tbl [N_OUT];
    logic [NV-1:0]   ref_mask [N_OUT];
    int              checks = 0;
    int              errors = 0;

    sop_sweep_checker #(.N_IN(N_IN), .N_OUT(N_OUT)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .mask_wr          (mask_wr),
        .mask_sel         (mask_sel),
        .mask_data        (mask_data),
        .start            (start),
        .dut_in           (dut_in),
        .dut_out          (dut_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx)
    );

    always #5 clk = ~clk;

`ifdef SWEEP_SETTLE_EN
    always @(posedge clk) dut_out <= {dut_tbl[1][dut_in], dut_tbl[0][dut_in]};
`else
    always_comb dut_out = {dut_tbl[1][dut_in], dut_tbl[0][dut_in]};
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Truth tables from the boolean equations; faulty drops the AB'D' term of F2.
    task automatic load_golden(input bit faulty);
        for (int i = 0; i < NV; i++) begin
            logic a, b, c, d;
            {a, b, c, d} = 4'(i);
            dut_tbl[0][i] = !b || (!a && !d);
            dut_tbl[1][i] = (b && d) || (c && d) || (!faulty && a && !b && !d);
        end
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic write_mask(input logic sel, input logic [NV-1:0] data);
        mask_wr = 1'b1; mask_sel = sel; mask_data = data;
        ref_mask[sel] = data;
        @(negedge clk);
        mask_wr = 1'b0;
    endtask

    // One sweep launched in the current cycle; optional same-cycle write, a write+start
    // injected while busy at cycle inj, or a reset asserted in cycle rst_at.
    task automatic sweep(input string tag, input logic wr, input logic sel,
                         input logic [NV-1:0] data, input int inj, input int rst_at);
        int cyc;
        int exp_err;
        int exp_ffi;
        logic exp_ffv;
        start = 1'b1;
        if (wr) begin
            mask_wr = 1'b1; mask_sel = sel; mask_data = data;
            ref_mask[sel] = data;
        end
        exp_err = 0; exp_ffi = 0; exp_ffv = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (dut_tbl[0][i] != ref_mask[0][i] || dut_tbl[1][i] != ref_mask[1][i]) begin
                if (!exp_ffv) begin
                    exp_ffv = 1'b1;
                    exp_ffi = i;
                end
                exp_err++;
            end
        end
        @(negedge clk);
        start = 1'b0; mask_wr = 1'b0;
        cyc = 1;
        check({tag, "_busy_c1"}, 32'(busy), 1);
        check({tag, "_dut_in_c1"}, 32'(dut_in), 0);
        while (!done && cyc < 200) begin
            if (cyc == inj) begin
                mask_wr = 1'b1; mask_sel = 1'b0; mask_data = '0; start = 1'b1;
            end
            if (cyc == rst_at) rst = 1'b1;
            @(negedge clk);
            cyc++;
            mask_wr = 1'b0; start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                check({tag, "_rst_busy"}, 32'(busy), 0);
                check({tag, "_rst_done"}, 32'(done), 0);
                check({tag, "_rst_err"}, 32'(err_count), 0);
                check({tag, "_rst_ffv"}, 32'(first_fail_valid), 0);
                check({tag, "_rst_pass"}, 32'(pass), 0);
                ref_mask[0] = '0;
                ref_mask[1] = '0;
                return;
            end
        end
        check({tag, "_done_cycle"}, 32'(cyc), 32'(SWEEP_CYC));
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_fin"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err_count), 32'(exp_err));
        check({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        check({tag, "_ffv"}, 32'(first_fail_valid), 32'(exp_ffv));
        check({tag, "_ffi"}, 32'(first_fail_idx), 32'(exp_ffi));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_err_hold"}, 32'(err_count), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1; mask_wr = 1'b0; mask_sel = '0; mask_data = '0; start = 1'b0;
        dut_tbl[0] = '0; dut_tbl[1] = '0;
        ref_mask[0] = '0; ref_mask[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_dut_in", 32'(dut_in), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_pass", 32'(pass), 0);
        check("reset_err", 32'(err_count), 0);
        check("reset_ffv", 32'(first_fail_valid), 0);
        check("reset_ffi", 32'(first_fail_idx), 0);
        sweep("reset_sweep", 1'b0, 1'b0, '0, 0, 0);

        write_mask(1'b0, 16'h0F5F);
        write_mask(1'b1, 16'hADA8);
        load_golden(1'b0);
        sweep("golden", 1'b0, 1'b0, '0, 0, 0);
        load_golden(1'b1);
        sweep("faulty", 1'b0, 1'b0, '0, 0, 0);
        load_golden(1'b0);
        sweep("busy_ignore", 1'b0, 1'b0, '0, 3, 0);
        sweep("wr_start", 1'b1, 1'b0, 16'h0000, 0, 0);
        write_mask(1'b0, 16'h0F5F);
        sweep("rst_mid", 1'b0, 1'b0, '0, 0, 5);
        sweep("after_rst", 1'b0, 1'b0, '0, 0, 0);

        for (int n = 0; n < 6; n++) begin
            write_mask(1'b0, NV'($urandom));
            write_mask(1'b1, NV'($urandom));
            for (int j = 0; j < N_OUT; j++) begin
                dut_tbl[j] = ref_mask[j] ^ (NV'($urandom) & NV'($urandom) & NV'($urandom));
            end
            sweep($sformatf("rand%0d", n), 1'b0, 1'b0, '0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
